seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Display stage directly downstream of the traffic-light countdown generator. Takes the 8-bit binary countdown value, converts it to three BCD digits with a sequential double-dabble converter, and time-multiplexes the digits onto a common-anode 3-digit 7-segment display. Glitch filtering discards the one-cycle 8'hFF wrap value the countdown briefly presents before reloading.

## Interface
- SCAN_DIV, 1000: clk cycles each digit stays enabled; legal range 2..65535.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- num_in  input  8  binary countdown value from upstream; unsigned, 0..255.
- seg  output  7  segment drive, active-low, {g,f,e,d,c,b,a}.
- an  output  3  digit enable, active-low, one-hot; an[0] is units, an[2] is hundreds.
- busy  output  1  high while a conversion is in progress.
- bcd  output  12  last converted value, {hundreds, tens, units}.

## Operation
- Input filter: num_q registers num_in every cycle. A value is accepted only when num_in == num_q (stable for 2 consecutive cycles) AND num_in != last_num AND converter is IDLE.
- Converter FSM states:
  - IDLE: on accept, load shift register {12'b0, num_in}, last_num <= num_in, bit_cnt <= 0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift left by 1, bit_cnt++. After the 8th shift, go to DONE.
  - DONE: bcd <= upper 12 bits of shift register, go to IDLE.
- busy = (state != IDLE).
- Changes on num_in during SHIFT/DONE are not queued. Once IDLE is re-entered, the filter is re-evaluated, so only the latest stable value is converted.
- Scan: prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and digit index advances 0 -> 1 -> 2 -> 0.
- Decode: the selected bcd nibble maps through the digit LUT: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles > 9 (unreachable) map to blank 1111111.
- seg and an are registered. They reflect the digit index and bcd of the previous cycle.

## Timing
- Reset values:
  - state=IDLE, last_num=0, num_q=0, bcd=12'h000, busy=0.
  - Prescaler=0, digit index=0.
  - seg=1000000, an=110.
- Conversion latency: num_in applied before edge N is registered into num_q at N. Accept occurs at N+1. bcd updates at N+10. busy is high for cycles N+1..N+9 (9 cycles).
- Minimum spacing between accepted values: 11 cycles.
- A single-cycle value (e.g. 8'hFF wrap pulse) is never accepted. The preceding and following values are unaffected.
- Reset asserted mid-conversion: abort to IDLE, bcd=0 on the next edge. The display shows 0 per reset values.
- Digit index and prescaler run independently of the converter. A bcd update takes effect on the next registered seg update without resetting the scan.

## Configuration
- SEG_BLANK_EN defined: leading-zero blanking.
  - Hundreds digit is blank (1111111) when hundreds==0.
  - Tens digit is blank when hundreds==0 and tens==0.
  - Units digit is never blanked.
  - an still cycles through all three digits.
- SEG_BLANK_EN undefined: all three digits always show their decoded value, zeros included.

## Structure
- Package seg_pkg holds:
  - Converter state enum {IDLE, SHIFT, DONE}.
  - SEG_BLANK = 7'b1111111.
  - 10-entry digit LUT as a function seg_decode(nibble).
  - AN reset constant 3'b110.
- Sub-module bin2bcd_seq contains the FSM, shift register, bit counter and busy. The top holds the filter, prescaler, digit mux and output registers.

## Test plan
- Reset, then hold num_in=0: seg=1000000, an=110 immediately after reset; bcd=000. Without SEG_BLANK_EN, all digits show 1000000 as an scans.
- SCAN_DIV=4, num_in=29 stable: bcd=12'h029 exactly 10 cycles after the first sampling edge. an sequence 110, 101, 011, each held 4 cycles. Units seg=0010000, tens seg=0100100, hundreds seg=1111111 with SEG_BLANK_EN (1000000 without).
- Count 1 -> 8'hFF for one cycle -> 14: 255 is never accepted (busy does not rise for it); bcd goes 001 -> 014.
- num_in=255 stable: bcd=12'h255. Digit segments are 0100100, 0010010, 0010010.
- Change num_in from 20 to 19 three cycles into a conversion of 20: bcd=020 first, then 019 at the earliest 11 cycles after the 20 accept.
- Assert rst during SHIFT: next edge bcd=000, busy=0, an=110. After release, a stable num_in=7 yields bcd=007 after 10 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the countdown display stage: converter
// states, blank pattern, digit-enable reset value and the 7-segment digit LUT.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [2:0] AN_RESET  = 3'b110;

    // Active-low {g,f,e,d,c,b,a}; codes above 9 cannot come out of the converter
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits,
// one shift per cycle, with a memory of the last accepted value.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        busy,
    output logic [11:0] bcd
);

    conv_state_t state, next_state;
    logic [19:0] shift_reg;
    logic [19:0] shift_adj;
    logic [2:0]  bit_cnt;
    logic [7:0]  last_num;
    logic        load;

    // A value already shown is not reconverted
    assign load = (state == IDLE) && start && (din != last_num);
    assign busy = (state != IDLE);

    always_comb begin
        shift_adj = shift_reg;
        for (int i = 0; i < 3; i++) begin
            if (shift_reg[8 + 4*i +: 4] >= 4'd5)
                shift_adj[8 + 4*i +: 4] = shift_reg[8 + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = SHIFT;
            SHIFT:   if (bit_cnt == 3'd7) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            last_num  <= '0;
            bcd       <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_reg <= {12'b0, din};
                        last_num  <= din;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_adj << 1;
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                DONE:    bcd <= shift_reg[19:8];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Countdown display driver: input glitch filter, BCD conversion and 3-digit
// common-anode scan. Define SEG_BLANK_EN for leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  num_in,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        busy,
    output logic [11:0] bcd
);

    localparam logic [15:0] PRESC_TC = 16'(SCAN_DIV - 1);

    logic [7:0]  num_q;
    logic [15:0] presc;
    logic [1:0]  digit_idx;
    logic [3:0]  nibble;
    logic [6:0]  seg_next;
    logic [2:0]  an_next;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (num_in == num_q),
        .din   (num_in),
        .busy  (busy),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            presc     <= '0;
            digit_idx <= '0;
        end else begin
            num_q <= num_in;
            if (presc == PRESC_TC) begin
                presc     <= '0;
                digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    always_comb begin
        nibble  = bcd[3:0];
        an_next = AN_RESET;
        case (digit_idx)
            2'd1: begin
                nibble  = bcd[7:4];
                an_next = 3'b101;
            end
            2'd2: begin
                nibble  = bcd[11:8];
                an_next = 3'b011;
            end
            default: ;
        endcase
        seg_next = seg_decode(nibble);
`ifdef SEG_BLANK_EN
        // Leading zeros go dark; the units digit always shows
        if (digit_idx == 2'd2 && bcd[11:8] == 4'd0)
            seg_next = SEG_BLANK;
        if (digit_idx == 2'd1 && bcd[11:4] == 8'd0)
            seg_next = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'b1000000;
            an  <= AN_RESET;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with a short scan period; honours
// SEG_BLANK_EN when predicting the displayed digits.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [7:0]  num_in;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        busy;
    logic [11:0] bcd;

    int vec_count   = 0;
    int miscompares = 0;
    int tick        = 0;
    logic [11:0] exp_q[$];
    logic [6:0]  lut [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

    seg_scan_driver #(.SCAN_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .num_in (num_in),
        .seg    (seg),
        .an     (an),
        .busy   (busy),
        .bcd    (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release, used to predict the scan position
    always @(posedge clk) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] toBcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic applyStimulus(input int v, input bit expect_accept);
        @(negedge clk);
        num_in = 8'(v);
        if (expect_accept) exp_q.push_back(toBcd(v));
    endtask

    task automatic checkScan(input int v, input int n);
        int d, h, t, u;
        logic [6:0] es;
        logic [2:0] ea;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = (tick == 0) ? 0 : ((tick - 1) / 4) % 3;
            ea = 3'b111;
            ea[d] = 1'b0;
            case (d)
                0:       es = lut[u];
                1:       es = lut[t];
                default: es = lut[h];
            endcase
`ifdef SEG_BLANK_EN
            if (d == 2 && h == 0) es = 7'b1111111;
            if (d == 1 && h == 0 && t == 0) es = 7'b1111111;
`endif
            checkOutput("an", {29'd0, an}, {29'd0, ea});
            checkOutput("seg", {25'd0, seg}, {25'd0, es});
        end
    endtask

    // Each completed conversion must match the oldest outstanding expectation
    initial begin : monitor
        int busy_cycles;
        bit prev_busy;
        logic [11:0] e;
        busy_cycles = 0;
        prev_busy   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy_cycles = 0;
                prev_busy   = 1'b0;
            end else begin
                if (busy) begin
                    busy_cycles++;
                end else if (prev_busy) begin
                    checkOutput("busy_len", busy_cycles, 9);
                    if (exp_q.size() == 0) begin
                        checkOutput("sb_underflow", {20'd0, bcd}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("bcd", {20'd0, bcd}, {20'd0, e});
                    end
                    busy_cycles = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        rst    = 1'b1;
        num_in = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_seg", {25'd0, seg}, 32'b1000000);
        checkOutput("rst_an", {29'd0, an}, 32'b110);
        checkOutput("rst_bcd", {20'd0, bcd}, 32'h000);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        checkScan(0, 12);

        // 29: exact conversion latency, then the scan pattern
        applyStimulus(29, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("lat_pre", {20'd0, bcd}, 32'h000);
        @(negedge clk);
        checkOutput("lat_29", {20'd0, bcd}, 32'h029);
        checkScan(29, 14);

        // Countdown wrap pulse must be ignored
        applyStimulus(1, 1'b1);
        repeat (12) @(negedge clk);
        applyStimulus(255, 1'b0);
        @(negedge clk);
        checkOutput("ff_busy0", {31'd0, busy}, 32'd0);
        num_in = 8'd14;
        exp_q.push_back(toBcd(14));
        @(negedge clk);
        checkOutput("ff_busy1", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("bcd_14", {20'd0, bcd}, 32'h014);

        applyStimulus(255, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("bcd_255", {20'd0, bcd}, 32'h255);
        checkScan(255, 14);

        // Change mid-conversion: 20 completes first, then 19
        applyStimulus(20, 1'b1);
        repeat (4) @(negedge clk);
        num_in = 8'd19;
        exp_q.push_back(toBcd(19));
        repeat (25) @(negedge clk);
        checkOutput("bcd_19", {20'd0, bcd}, 32'h019);

        // Reset in the middle of a conversion
        applyStimulus(50, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_bcd", {20'd0, bcd}, 32'h000);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_an", {29'd0, an}, 32'b110);
        rst    = 1'b0;
        num_in = 8'd7;
        exp_q.push_back(toBcd(7));
        repeat (10) @(negedge clk);
        checkOutput("lat7_pre", {20'd0, bcd}, 32'h000);
        @(negedge clk);
        checkOutput("bcd_7", {20'd0, bcd}, 32'h007);
        checkScan(7, 12);

        repeat (3) @(negedge clk);
        checkOutput("sb_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
